// File: rtl/wb_retire_if.sv
// wb_retire_if: retire-stage bus carrying the packet handshake in, plus the register-file
// write port, the retire report and the bypass lookup out. slave = retire stage, master = its environment.
interface wb_retire_if #(
    parameter int N_param = 32
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [4:0]         in_rd_i;
    logic [N_param-1:0] in_data_i;
    logic               in_we_i;
    logic [N_param-1:0] in_pc_i;
    logic               stall_i;
    logic               flush_i;
    logic               we_po;
    logic [4:0]         destReg_po;
    logic [N_param-1:0] writeData_po;
    logic               retire_valid_o;
    logic [N_param-1:0] retire_pc_o;
    logic [63:0]        instret_o;
    logic [4:0]         rs1_i;
    logic [4:0]         rs2_i;
    logic               fwd1_hit_o;
    logic               fwd2_hit_o;
    logic [N_param-1:0] fwd1_data_o;
    logic [N_param-1:0] fwd2_data_o;

    modport slave (
        input  in_valid_i, in_rd_i, in_data_i, in_we_i, in_pc_i, stall_i, flush_i, rs1_i, rs2_i,
        output in_ready_o, we_po, destReg_po, writeData_po, retire_valid_o, retire_pc_o, instret_o,
               fwd1_hit_o, fwd2_hit_o, fwd1_data_o, fwd2_data_o
    );

    modport master (
        output in_valid_i, in_rd_i, in_data_i, in_we_i, in_pc_i, stall_i, flush_i, rs1_i, rs2_i,
        input  in_ready_o, we_po, destReg_po, writeData_po, retire_valid_o, retire_pc_o, instret_o,
               fwd1_hit_o, fwd2_hit_o, fwd1_data_o, fwd2_data_o
    );
endinterface

// File: rtl/wb_retire.sv
// wb_retire: in-order retire FIFO feeding the register-file write port, with a 64-bit retire counter.
// Optional macro WB_BYPASS_EN adds combinational rs1/rs2 bypass from buffered and presented writes.
module wb_retire #(
    parameter int N_param = 32,
    parameter int DEPTH   = 2
) (
    input  logic       clk,
    input  logic       reset,
    wb_retire_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [4:0]         rd_mem   [DEPTH];
    logic [N_param-1:0] data_mem [DEPTH];
    logic               we_mem   [DEPTH];
    logic [N_param-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               ready;
    logic               push;
    logic               pop;

    logic               we_q;
    logic [4:0]         dest_q;
    logic [N_param-1:0] wdata_q;
    logic               rv_q;
    logic [N_param-1:0] rpc_q;
    logic [63:0]        instret_q;

    // Ready depends only on the registered count; a pop in the same cycle does not free a slot.
    assign ready = count < CNT_W'(DEPTH);
    assign push  = bus.in_valid_i && ready && !bus.flush_i;
    assign pop   = !bus.stall_i && (count != '0) && !bus.flush_i;

    // NOTE: storage has no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= bus.in_rd_i;
            data_mem[tail] <= bus.in_data_i;
            we_mem[tail]   <= bus.in_we_i;
            pc_mem[tail]   <= bus.in_pc_i;
        end
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            we_q      <= 1'b0;
            dest_q    <= '0;
            wdata_q   <= '0;
            rv_q      <= 1'b0;
            rpc_q     <= '0;
            instret_q <= '0;
        end else begin
            if (bus.flush_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (pop) begin
                we_q      <= we_mem[head] && (rd_mem[head] != 5'd0);
                dest_q    <= rd_mem[head];
                wdata_q   <= data_mem[head];
                rv_q      <= 1'b1;
                rpc_q     <= pc_mem[head];
                instret_q <= instret_q + 64'd1;
            end else begin
                we_q <= 1'b0;
                rv_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o     = ready;
    assign bus.we_po          = we_q;
    assign bus.destReg_po     = dest_q;
    assign bus.writeData_po   = wdata_q;
    assign bus.retire_valid_o = rv_q;
    assign bus.retire_pc_o    = rpc_q;
    assign bus.instret_o      = instret_q;

`ifdef WB_BYPASS_EN
    logic               hit1;
    logic               hit2;
    logic [N_param-1:0] fd1;
    logic [N_param-1:0] fd2;

    // Oldest entry is scanned first so a younger match overrides it; the write port ranks below the FIFO.
    always_comb begin : bypass
        logic [PTR_W-1:0] idx;
        // NOTE: every output gets a default first so no path infers a latch.
        idx  = '0;
        hit1 = we_q && (dest_q == bus.rs1_i) && (bus.rs1_i != 5'd0);
        fd1  = hit1 ? wdata_q : '0;
        hit2 = we_q && (dest_q == bus.rs2_i) && (bus.rs2_i != 5'd0);
        fd2  = hit2 ? wdata_q : '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && we_mem[idx]) begin
                if ((rd_mem[idx] == bus.rs1_i) && (bus.rs1_i != 5'd0)) begin
                    hit1 = 1'b1;
                    fd1  = data_mem[idx];
                end
                if ((rd_mem[idx] == bus.rs2_i) && (bus.rs2_i != 5'd0)) begin
                    hit2 = 1'b1;
                    fd2  = data_mem[idx];
                end
            end
        end
    end

    assign bus.fwd1_hit_o  = hit1;
    assign bus.fwd2_hit_o  = hit2;
    assign bus.fwd1_data_o = fd1;
    assign bus.fwd2_data_o = fd2;
`else
    logic unused_rs;
    assign unused_rs       = ^{bus.rs1_i, bus.rs2_i};
    assign bus.fwd1_hit_o  = 1'b0;
    assign bus.fwd2_hit_o  = 1'b0;
    assign bus.fwd1_data_o = '0;
    assign bus.fwd2_data_o = '0;
`endif
endmodule

// File: tb/tb_wb_retire.sv
// tb_wb_retire: directed vector table, hand-written corner sequences and random traffic
// checked against a queue-based model of the retire stage.
module tb_wb_retire;
    localparam int N     = 32;
    localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_retire_if #(.N_param(N)) bus ();
    wb_retire #(.N_param(N), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [31:0] pc;
    } pkt_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_dest;
        logic [31:0] e_wdata;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic [63:0] e_instret;
    } vec_t;

    int checks = 0;
    int errors = 0;

    pkt_t        mq[$];
    logic        m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_wdata;
    logic        m_rv;
    logic [31:0] m_rpc;
    logic [63:0] m_instret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we      = 1'b0;
        m_dest    = '0;
        m_wdata   = '0;
        m_rv      = 1'b0;
        m_rpc     = '0;
        m_instret = '0;
    endtask

    // One clock edge of the retire stage, stated as queue operations.
    task automatic model_edge();
        pkt_t p;
        bit   do_push;
        bit   do_pop;
        do_push = bus.in_valid_i && (mq.size() < DEPTH) && !bus.flush_i;
        do_pop  = !bus.stall_i && (mq.size() > 0) && !bus.flush_i;
        if (bus.flush_i) begin
            mq.delete();
            m_we = 1'b0;
            m_rv = 1'b0;
        end else begin
            if (do_pop) begin
                p         = mq.pop_front();
                m_we      = p.we && (p.rd != 5'd0);
                m_dest    = p.rd;
                m_wdata   = p.data;
                m_rv      = 1'b1;
                m_rpc     = p.pc;
                m_instret = m_instret + 64'd1;
            end else begin
                m_we = 1'b0;
                m_rv = 1'b0;
            end
            if (do_push) begin
                p.rd   = bus.in_rd_i;
                p.data = bus.in_data_i;
                p.we   = bus.in_we_i;
                p.pc   = bus.in_pc_i;
                mq.push_back(p);
            end
        end
    endtask

    function automatic void exp_fwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (BYP && rs != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
                if (mq[i].we && mq[i].rd == rs) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                end
            end
            if (!hit && m_we && m_dest == rs) begin
                hit = 1'b1;
                d   = m_wdata;
            end
        end
    endfunction

    task automatic check_all();
        logic        h1, h2;
        logic [31:0] d1, d2;
        exp_fwd(bus.rs1_i, h1, d1);
        exp_fwd(bus.rs2_i, h2, d2);
        check("in_ready", 64'(bus.in_ready_o), 64'(mq.size() < DEPTH));
        check("we_po", 64'(bus.we_po), 64'(m_we));
        check("destReg_po", 64'(bus.destReg_po), 64'(m_dest));
        check("writeData_po", 64'(bus.writeData_po), 64'(m_wdata));
        check("retire_valid", 64'(bus.retire_valid_o), 64'(m_rv));
        check("retire_pc", 64'(bus.retire_pc_o), 64'(m_rpc));
        check("instret", bus.instret_o, m_instret);
        check("fwd1_hit", 64'(bus.fwd1_hit_o), 64'(h1));
        check("fwd2_hit", 64'(bus.fwd2_hit_o), 64'(h2));
        if (h1 || !BYP) check("fwd1_data", 64'(bus.fwd1_data_o), 64'(d1));
        if (h2 || !BYP) check("fwd2_data", 64'(bus.fwd2_data_o), 64'(d2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic we,
                         input logic [31:0] pc, input logic st, input logic fl);
        bus.in_valid_i = v;
        bus.in_rd_i    = rd;
        bus.in_data_i  = d;
        bus.in_we_i    = we;
        bus.in_pc_i    = pc;
        bus.stall_i    = st;
        bus.flush_i    = fl;
    endtask

    vec_t vecs[21];

    initial begin
        // inputs: valid rd data we pc stall flush | after edge: ready we dest wdata rv rpc instret
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 64'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'h10, 64'd1};
        vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h10, 64'd1};
        vecs[3]  = '{1'b1, 5'd1, 32'hA1, 1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h10, 64'd1};
        vecs[4]  = '{1'b1, 5'd2, 32'hB2, 1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h10, 64'd1};
        vecs[5]  = '{1'b1, 5'd3, 32'hC3, 1'b1, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h10, 64'd1};
        vecs[6]  = '{1'b1, 5'd3, 32'hC3, 1'b1, 32'h28, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA1, 1'b1, 32'h20, 64'd2};
        vecs[7]  = '{1'b1, 5'd3, 32'hC3, 1'b1, 32'h28, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'hB2, 1'b1, 32'h24, 64'd3};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hC3, 1'b1, 32'h28, 64'd4};
        vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'hC3, 1'b0, 32'h28, 64'd4};
        vecs[10] = '{1'b1, 5'd0, 32'h1234, 1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'hC3, 1'b0, 32'h28, 64'd4};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b1, 32'h30, 64'd5};
        vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 32'h30, 64'd5};
        vecs[13] = '{1'b1, 5'd4, 32'hD4, 1'b1, 32'h34, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 32'h30, 64'd5};
        vecs[14] = '{1'b1, 5'd5, 32'hE5, 1'b1, 32'h38, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1234, 1'b0, 32'h30, 64'd5};
        vecs[15] = '{1'b1, 5'd9, 32'h99, 1'b1, 32'h3A, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 32'h30, 64'd5};
        vecs[16] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 32'h30, 64'd5};
        vecs[17] = '{1'b1, 5'd6, 32'hF6, 1'b1, 32'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 32'h30, 64'd5};
        vecs[18] = '{1'b1, 5'd7, 32'h77, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'hF6, 1'b1, 32'h3C, 64'd6};
        vecs[19] = '{1'b1, 5'd8, 32'h88, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'hF6, 1'b0, 32'h3C, 64'd6};
        vecs[20] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'hF6, 1'b0, 32'h3C, 64'd6};

        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        bus.rs1_i = 5'd0;
        bus.rs2_i = 5'd0;
        reset = 1'b1;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].rd, vecs[i].data, vecs[i].we, vecs[i].pc, vecs[i].stall, vecs[i].flush);
            tick();
            check($sformatf("vec%0d.ready", i), 64'(bus.in_ready_o), 64'(vecs[i].e_ready));
            check($sformatf("vec%0d.we", i), 64'(bus.we_po), 64'(vecs[i].e_we));
            check($sformatf("vec%0d.dest", i), 64'(bus.destReg_po), 64'(vecs[i].e_dest));
            check($sformatf("vec%0d.wdata", i), 64'(bus.writeData_po), 64'(vecs[i].e_wdata));
            check($sformatf("vec%0d.rv", i), 64'(bus.retire_valid_o), 64'(vecs[i].e_rv));
            check($sformatf("vec%0d.rpc", i), 64'(bus.retire_pc_o), 64'(vecs[i].e_rpc));
            check($sformatf("vec%0d.instret", i), bus.instret_o, vecs[i].e_instret);
        end

        // Two writes to x7 buffered under stall: the younger one must be forwarded.
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h1, 1'b1, 32'h50, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h2, 1'b1, 32'h54, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        bus.rs1_i = 5'd7;
        bus.rs2_i = 5'd0;
        #1;
        check("byp.fwd1_hit", 64'(bus.fwd1_hit_o), 64'(BYP));
        check("byp.fwd1_data", 64'(bus.fwd1_data_o), BYP ? 64'h2 : 64'h0);
        check("byp.fwd2_hit", 64'(bus.fwd2_hit_o), 64'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        bus.rs1_i = 5'd0;

        // Counter wrap: preload all-ones, then retire one packet.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        check("wrap.preload", bus.instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h9999, 1'b1, 32'h60, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check("wrap.instret", bus.instret_o, 64'd0);
        check("wrap.we", 64'(bus.we_po), 64'd1);

        // Async reset between edges with a write on the port and one packet buffered.
        @(negedge clk);
        drive(1'b1, 5'd10, 32'hAAAA, 1'b1, 32'h70, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        drive(1'b1, 5'd11, 32'hBBBB, 1'b1, 32'h74, 1'b0, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("areset.we", 64'(bus.we_po), 64'd0);
        check("areset.rv", 64'(bus.retire_valid_o), 64'd0);
        check("areset.dest", 64'(bus.destReg_po), 64'd0);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0,
                  $urandom, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
            bus.rs1_i = 5'($urandom_range(0, 7));
            bus.rs2_i = 5'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
